// File: rtl/mag_req_arbiter.sv
// Round-robin front end sharing one sqrt(a^2+b^2) unit between N requesters; tracks in-flight IDs
// and routes results back in order. Optional watchdog: define MAG_ARB_WDOG_EN.
module mag_req_arbiter #(
  parameter int N            = 4,
  parameter int IDW          = 2,
  parameter int MAX_INFLIGHT = 8,
  parameter int WDOG_CYC     = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req_vld,
  input  logic [N*8-1:0]   req_a,
  input  logic [N*8-1:0]   req_b,
  output logic [N-1:0]     req_rdy,
  output logic [7:0]       u_a,
  output logic [7:0]       u_b,
  output logic             u_i_vld,
  input  logic             u_o_vld,
  input  logic [7:0]       u_sqrt,
  input  logic [15:0]      u_remain,
  output logic [N-1:0]     rsp_vld,
  output logic [IDW-1:0]   rsp_id,
  output logic [7:0]       rsp_sqrt,
  output logic [15:0]      rsp_remain,
  output logic             err_spur,
  output logic             err_tmo
);

  localparam int PW = $clog2(MAX_INFLIGHT);
  localparam int CW = $clog2(MAX_INFLIGHT + 1);

  logic [IDW-1:0] r_ptr;
  logic [CW-1:0]  r_inflight;
  logic [PW-1:0]  r_wr;
  logic [PW-1:0]  r_rd;
  logic [IDW-1:0] r_fifo [MAX_INFLIGHT];
  logic           r_u_i_vld;
  logic [7:0]     r_u_a;
  logic [7:0]     r_u_b;
  logic [N-1:0]   r_rsp_vld;
  logic [IDW-1:0] r_rsp_id;
  logic [7:0]     r_rsp_sqrt;
  logic [15:0]    r_rsp_remain;
  logic           r_spur;

  logic [7:0]     w_a [N];
  logic [7:0]     w_b [N];
  logic           w_found;
  logic [IDW-1:0] w_win;
  logic [IDW-1:0] w_idx;
  logic           w_full;
  logic           w_acc;
  logic           w_pop;
  logic           w_tmo;
  logic [N-1:0]   w_gnt;

  for (genvar gi = 0; gi < N; gi++) begin : g_ops
    assign w_a[gi] = req_a[8*gi +: 8];
    assign w_b[gi] = req_b[8*gi +: 8];
  end

  // Walk offsets from far to near so the channel closest after the pointer wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_idx   = '0;
    for (int k = N; k >= 1; k--) begin
      w_idx = IDW'((int'(r_ptr) + k) % N);
      if (req_vld[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx;
      end
    end
  end

  assign w_full = (r_inflight == CW'(MAX_INFLIGHT));
  assign w_acc  = w_found & ~w_full;
  assign w_pop  = u_o_vld & (r_inflight != '0);

  always_comb begin
    w_gnt = '0;
    if (w_acc) w_gnt[w_win] = 1'b1;
  end

  assign req_rdy = w_gnt;

`ifdef MAG_ARB_WDOG_EN
  localparam int WW = $clog2(WDOG_CYC + 1);
  logic [WW-1:0] r_wdog;
  logic          r_tmo;

  assign w_tmo = (r_inflight != '0) & ~u_o_vld & (r_wdog == WW'(WDOG_CYC));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wdog <= '0;
      r_tmo  <= 1'b0;
    end else begin
      r_tmo <= w_tmo;
      if (r_inflight == '0 || u_o_vld || w_tmo) r_wdog <= '0;
      else                                      r_wdog <= r_wdog + 1'b1;
    end
  end

  assign err_tmo = r_tmo;
`else
  assign w_tmo   = 1'b0 & (WDOG_CYC > 0);
  assign err_tmo = 1'b0;
`endif

  // ID storage holds no state worth resetting; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (rst_n && w_acc) r_fifo[r_wr] <= w_win;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ptr        <= IDW'(N - 1);
      r_inflight   <= '0;
      r_wr         <= '0;
      r_rd         <= '0;
      r_u_i_vld    <= 1'b0;
      r_u_a        <= '0;
      r_u_b        <= '0;
      r_rsp_vld    <= '0;
      r_rsp_id     <= '0;
      r_rsp_sqrt   <= '0;
      r_rsp_remain <= '0;
      r_spur       <= 1'b0;
    end else begin
      r_u_i_vld <= w_acc;
      r_rsp_vld <= '0;
      if (w_acc) begin
        r_ptr <= w_win;
        r_u_a <= w_a[w_win];
        r_u_b <= w_b[w_win];
        r_wr  <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rsp_vld[r_fifo[r_rd]] <= 1'b1;
        r_rsp_id                <= r_fifo[r_rd];
        r_rsp_sqrt              <= u_sqrt;
        r_rsp_remain            <= u_remain;
        r_rd                    <= r_rd + 1'b1;
      end
      if (u_o_vld && r_inflight == '0) r_spur <= 1'b1;
      // A flush keeps an accept from the same cycle as the sole surviving entry.
      if (w_tmo) begin
        r_rd       <= r_wr;
        r_inflight <= CW'(w_acc);
      end else if (w_acc && !w_pop) begin
        r_inflight <= r_inflight + 1'b1;
      end else if (!w_acc && w_pop) begin
        r_inflight <= r_inflight - 1'b1;
      end
    end
  end

  assign u_i_vld    = r_u_i_vld;
  assign u_a        = r_u_a;
  assign u_b        = r_u_b;
  assign rsp_vld    = r_rsp_vld;
  assign rsp_id     = r_rsp_id;
  assign rsp_sqrt   = r_rsp_sqrt;
  assign rsp_remain = r_rsp_remain;
  assign err_spur   = r_spur;

endmodule

// File: tb/tb_mag_req_arbiter.sv
// Directed bench for mag_req_arbiter with an in-order magnitude unit model (latency 17, stallable).
`timescale 1ns/1ps
module tb_mag_req_arbiter;
  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int LAT = 17;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N-1:0]     req_vld;
  logic [N*8-1:0]   req_a, req_b;
  logic [N-1:0]     req_rdy;
  logic [7:0]       u_a, u_b;
  logic             u_i_vld;
  logic             u_o_vld;
  logic [7:0]       u_sqrt;
  logic [15:0]      u_remain;
  logic [N-1:0]     rsp_vld;
  logic [IDW-1:0]   rsp_id;
  logic [7:0]       rsp_sqrt;
  logic [15:0]      rsp_remain;
  logic             err_spur, err_tmo;

  always #5 clk = ~clk;

  mag_req_arbiter #(.N(N), .IDW(IDW), .MAX_INFLIGHT(8), .WDOG_CYC(64)) dut (
    .clk(clk), .rst_n(rst_n), .req_vld(req_vld), .req_a(req_a), .req_b(req_b),
    .req_rdy(req_rdy), .u_a(u_a), .u_b(u_b), .u_i_vld(u_i_vld), .u_o_vld(u_o_vld),
    .u_sqrt(u_sqrt), .u_remain(u_remain), .rsp_vld(rsp_vld), .rsp_id(rsp_id),
    .rsp_sqrt(rsp_sqrt), .rsp_remain(rsp_remain), .err_spur(err_spur), .err_tmo(err_tmo)
  );

  // ---------------- unit model ----------------
  typedef struct { logic [7:0] a; logic [7:0] b; int due; } op_t;
  op_t         mq[$];
  int          cyc = 0;
  logic        m_vld = 1'b0;
  logic [7:0]  m_sqrt = '0;
  logic [15:0] m_rem = '0;
  logic        stall, inj;
  int          rel_cnt;
  int          rel_used = 0;

  function automatic int sumsq(input logic [7:0] a, input logic [7:0] b);
    int sa, sb;
    sa = $signed(a);
    sb = $signed(b);
    return sa * sa + sb * sb;
  endfunction

  function automatic int isqrt(input int s);
    int r = 0;
    while ((r + 1) * (r + 1) <= s) r++;
    return r;
  endfunction

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      mq.delete();
      m_vld    <= 1'b0;
      rel_used <= 0;
    end else begin
      if (u_i_vld) mq.push_back('{a: u_a, b: u_b, due: cyc + LAT});
      if (mq.size() > 0 && cyc >= mq[0].due && (!stall || rel_used < rel_cnt)) begin
        m_vld  <= 1'b1;
        m_sqrt <= 8'(isqrt(sumsq(mq[0].a, mq[0].b)));
        m_rem  <= 16'(sumsq(mq[0].a, mq[0].b) - isqrt(sumsq(mq[0].a, mq[0].b)) ** 2);
        mq.pop_front();
        if (stall) rel_used <= rel_used + 1;
      end else begin
        m_vld <= 1'b0;
      end
    end
  end

  assign u_o_vld  = m_vld | inj;
  assign u_sqrt   = m_sqrt;
  assign u_remain = m_rem;

  // ---------------- monitor ----------------
  typedef struct { logic [3:0] v; logic [1:0] id; logic [7:0] s; logic [15:0] r; } rsp_t;
  int   gnt_q[$];
  int   gnt_cyc[$];
  rsp_t rsp_q[$];
  int   pop_cyc = -1;
  int   tmo_cyc = -1;

  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < N; i++) begin
        if (req_vld[i] && req_rdy[i]) begin
          gnt_q.push_back(i);
          gnt_cyc.push_back(cyc);
          $display("grant ch%0d a=%h b=%h cyc=%0d", i, req_a[8*i +: 8], req_b[8*i +: 8], cyc);
        end
      end
      if (|rsp_vld) begin
        rsp_q.push_back('{v: rsp_vld, id: rsp_id, s: rsp_sqrt, r: rsp_remain});
        $display("resp vld=%b id=%0d sqrt=%0d rem=%0d cyc=%0d", rsp_vld, rsp_id, rsp_sqrt, rsp_remain, cyc);
      end
      if (u_o_vld) pop_cyc <= cyc;
      if (err_tmo) tmo_cyc <= cyc;
    end
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && gnt_q.size() < n; i++) tick();
    check({tag, "_grants"}, gnt_q.size(), n);
  endtask

  task automatic wait_rsp(input int n, input int budget, input string tag);
    for (int i = 0; i < budget && rsp_q.size() < n; i++) tick();
    check({tag, "_resps"}, rsp_q.size(), n);
  endtask

  task automatic req1(input int ch, input logic [7:0] a, input logic [7:0] b, input string tag);
    int n0;
    n0 = gnt_q.size();
    req_a[8*ch +: 8] = a;
    req_b[8*ch +: 8] = b;
    req_vld[ch] = 1'b1;
    wait_gnt(n0 + 1, 30, tag);
    req_vld[ch] = 1'b0;
    check({tag, "_gnt_ch"}, (gnt_q.size() > n0) ? gnt_q[n0] : -1, ch);
    check({tag, "_u_i_vld"}, u_i_vld, 1);
    check({tag, "_u_a"}, u_a, a);
    check({tag, "_u_b"}, u_b, b);
  endtask

  task automatic reset_chk(input string tag);
    check({tag, "_u_i_vld"}, u_i_vld, 0);
    check({tag, "_rsp_vld"}, rsp_vld, 0);
    check({tag, "_err_spur"}, err_spur, 0);
    check({tag, "_err_tmo"}, err_tmo, 0);
    check({tag, "_u_ab"}, {u_a, u_b}, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    check({tag, "_rsp_data"}, {rsp_sqrt, rsp_remain}, 0);
  endtask

  task automatic chk_rsp(input int idx, input string tag, input logic [3:0] v, input logic [1:0] id,
                         input logic [7:0] s, input logic [15:0] r);
    rsp_t x;
    if (idx < rsp_q.size()) x = rsp_q[idx];
    else x = '{v: 4'hx, id: 2'bx, s: 8'hx, r: 16'hx};
    check({tag, "_vld"}, x.v, v);
    check({tag, "_id"}, x.id, id);
    check({tag, "_sqrt"}, x.s, s);
    check({tag, "_rem"}, x.r, r);
  endtask

  logic [7:0]  t3a [4] = '{8'd3, 8'd5, 8'hF9, 8'd1};
  logic [7:0]  t3b [4] = '{8'd4, 8'd12, 8'd24, 8'd1};
  logic [7:0]  t3s [4] = '{8'd5, 8'd13, 8'd25, 8'd1};
  logic [15:0] t3r [4] = '{16'd0, 16'd0, 16'd0, 16'd1};

  initial begin
    int g0, r0;
    rst_n = 1'b0; req_vld = '0; req_a = '0; req_b = '0;
    inj = 1'b0; stall = 1'b0; rel_cnt = 0;
    repeat (2) tick();
    reset_chk("por");
    rst_n = 1'b1;

    // single requests with large negative and mixed operands
    r0 = rsp_q.size();
    req1(0, 8'h80, 8'h80, "t1");
    wait_rsp(r0 + 1, 60, "t1");
    chk_rsp(r0, "t1", 4'b0001, 2'd0, 8'd181, 16'd7);
    r0 = rsp_q.size();
    req1(2, 8'hFF, 8'hFF, "t2a");
    req1(1, 8'h93, 8'hAA, "t2b");
    wait_rsp(r0 + 2, 60, "t2");
    chk_rsp(r0,     "t2a", 4'b0100, 2'd2, 8'd1,   16'd1);
    chk_rsp(r0 + 1, "t2b", 4'b0010, 2'd1, 8'd138, 16'd233);

    // all channels requesting: round-robin from ch0, one accept per cycle
    rst_n = 1'b0; tick(); reset_chk("rst3"); rst_n = 1'b1;
    g0 = gnt_q.size(); r0 = rsp_q.size();
    for (int i = 0; i < N; i++) begin
      req_a[8*i +: 8] = t3a[i];
      req_b[8*i +: 8] = t3b[i];
    end
    req_vld = 4'hF;
    wait_gnt(g0 + 8, 30, "t3");
    req_vld = '0;
    for (int i = 0; i < 8; i++) check($sformatf("t3_order%0d", i), (g0 + i < gnt_q.size()) ? gnt_q[g0 + i] : -1, i % 4);
    check("t3_span", (g0 + 7 < gnt_cyc.size()) ? gnt_cyc[g0 + 7] - gnt_cyc[g0] : -1, 7);
    wait_rsp(r0 + 8, 80, "t3");
    for (int i = 0; i < 8; i++)
      chk_rsp(r0 + i, $sformatf("t3_r%0d", i), 4'(1 << (i % 4)), 2'(i % 4), t3s[i % 4], t3r[i % 4]);

    // stalled unit: fill to capacity, one return frees exactly one slot next cycle
    stall = 1'b1;
    g0 = gnt_q.size();
    req_vld = 4'hF;
    repeat (30) tick();
    check("t4_full_grants", gnt_q.size(), g0 + 8);
    check("t4_rdy_full", req_rdy, 0);
    rel_cnt = 1;
    wait_gnt(g0 + 9, 40, "t4_rel");
    check("t4_gap", (g0 + 8 < gnt_cyc.size()) ? gnt_cyc[g0 + 8] - pop_cyc : -1, 1);
    repeat (10) tick();
    check("t4_after_grants", gnt_q.size(), g0 + 9);
    check("t4_rdy_again", req_rdy, 0);
    req_vld = '0;

    // spurious result strobe
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    stall = 1'b0; rel_cnt = 0;
    r0 = rsp_q.size();
    inj = 1'b1; tick(); inj = 1'b0;
    repeat (3) tick();
    check("t5_spur_set", err_spur, 1);
    check("t5_no_rsp", rsp_q.size(), r0);
    repeat (5) tick();
    check("t5_spur_held", err_spur, 1);

    // reset with three in flight
    stall = 1'b1;
    g0 = gnt_q.size();
    req_vld = 4'hF;
    wait_gnt(g0 + 3, 20, "t5b");
    req_vld = '0;
    for (int i = 0; i < 3; i++) check($sformatf("t5b_order%0d", i), (g0 + i < gnt_q.size()) ? gnt_q[g0 + i] : -1, i);
    tick();
    rst_n = 1'b0; tick(); reset_chk("rst5"); rst_n = 1'b1;
    stall = 1'b0;
    g0 = gnt_q.size(); r0 = rsp_q.size();
    req_vld = 4'hF;
    wait_gnt(g0 + 1, 10, "t5c");
    req_vld = '0;
    check("t5c_first_ch", (g0 < gnt_q.size()) ? gnt_q[g0] : -1, 0);
    wait_rsp(r0 + 1, 60, "t5c");
    check("t5c_rsp_id", (r0 < rsp_q.size()) ? rsp_q[r0].id : 2'bx, 0);
    check("t5c_no_spur", err_spur, 0);

`ifdef MAG_ARB_WDOG_EN
    // lost results: watchdog flushes and the arbiter resumes
    stall = 1'b1;
    g0 = gnt_q.size();
    req_vld = 4'b0011;
    wait_gnt(g0 + 2, 10, "t6");
    req_vld = '0;
    for (int i = 0; i < 100 && tmo_cyc < 0; i++) tick();
    check("t6_tmo_delay", (g0 + 1 < gnt_cyc.size() && tmo_cyc >= 0) ? tmo_cyc - (gnt_cyc[g0 + 1] + 1) : -1, 64);
    req1(2, 8'd6, 8'd8, "t6_resume");
`else
    // no watchdog: a lost result never raises err_tmo
    stall = 1'b1;
    req1(1, 8'd6, 8'd8, "t6");
    repeat (90) tick();
    check("t6_no_tmo", tmo_cyc, -1);
    check("t6_err_tmo", err_tmo, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
